// File: rtl/equiv_pkg.sv
// Shared types for the equivalence mismatch monitor: FSM states and the mismatch record payload.
package equiv_pkg;

    localparam int unsigned MON_W  = 91;
    localparam int unsigned MON_CW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } mon_state_t;

    typedef struct packed {
        logic [MON_CW-1:0] cyc;
        logic [MON_W-1:0]  diff;
    } mis_rec_t;

endpackage

// File: rtl/equiv_rec_fifo.sv
// Mismatch record FIFO: DEPTH entries, extra-bit pointers, flush, and push-when-full allowed with a same-cycle pop.
module equiv_rec_fifo
    import equiv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  logic     push,
    input  mis_rec_t push_rec,
    input  logic     pop,
    output mis_rec_t head,
    output logic     empty,
    output logic     full,
    output logic     drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    mis_rec_t    mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop_c  = push & full & ~pop_ok;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // When full with a pop, the write lands in the slot being vacated; the new head is read from rd_ptr+1.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= push_rec;
    end

endmodule

// File: rtl/equiv_mismatch_monitor.sv
// Compares two implementation outputs each cycle, counts mismatches and streams {cycle, y_1^y_2} records.
module equiv_mismatch_monitor
    import equiv_pkg::*;
#(
    parameter int unsigned W            = MON_W,
    parameter int unsigned CW           = MON_CW,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned WARMUP_CYC   = 2,
    parameter int unsigned RUN_CYC      = 1024,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  y_1,
    input  logic [W-1:0]  y_2,
    output logic          rec_valid,
    input  logic          rec_ready,
    output logic [CW-1:0] rec_cycle,
    output logic [W-1:0]  rec_diff,
    output logic [CW-1:0] cycle_cnt,
    output logic [CW-1:0] mismatch_cnt,
    output logic          fail,
    output logic          overflow,
    output logic          busy
);

    localparam int unsigned WARM_W    = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int unsigned WARM_LAST = (WARMUP_CYC > 0) ? WARMUP_CYC - 1 : 0;
    localparam int unsigned RUN_LAST  = (RUN_CYC > 0) ? RUN_CYC - 1 : 0;
    localparam mon_state_t  START_ST  = (WARMUP_CYC == 0) ? RUN : WARMUP;
    localparam logic [CW-1:0] CNT_MAX = '1;

    mon_state_t        state;
    logic [WARM_W-1:0] warm_cnt;
    logic [W-1:0]      s1_y_1;
    logic [W-1:0]      s1_y_2;
    logic [W-1:0]      diff_c;
    logic              mis_c;
    logic              run_end_c;
    logic              start_ok_c;
    logic              push_c;
    logic              drop_c;
    logic              empty;
    logic              full;
    mis_rec_t          push_rec;
    mis_rec_t          head;

    // Input stage: the compare always sees the values sampled one edge earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_y_1 <= '0;
            s1_y_2 <= '0;
        end else begin
            s1_y_1 <= y_1;
            s1_y_2 <= y_2;
        end
    end

    assign diff_c     = s1_y_1 ^ s1_y_2;
    assign mis_c      = |diff_c;
    assign run_end_c  = (RUN_CYC != 0) && (cycle_cnt == CW'(RUN_LAST));
    assign start_ok_c = start && ((state == IDLE) || (state == DONE));
    assign push_c     = (state == RUN) && mis_c;
    assign push_rec   = '{cyc: MON_CW'(cycle_cnt), diff: MON_W'(diff_c)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            warm_cnt     <= '0;
            cycle_cnt    <= '0;
            mismatch_cnt <= '0;
            fail         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= START_ST;
                        warm_cnt     <= '0;
                        cycle_cnt    <= '0;
                        mismatch_cnt <= '0;
                        fail         <= 1'b0;
                        overflow     <= 1'b0;
                    end
                end
                WARMUP: begin
                    if (warm_cnt == WARM_W'(WARM_LAST)) begin
                        state    <= RUN;
                        warm_cnt <= '0;
                    end else begin
                        warm_cnt <= warm_cnt + WARM_W'(1);
                    end
                end
                RUN: begin
                    cycle_cnt <= cycle_cnt + CW'(1);
                    if (mis_c) begin
                        if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + CW'(1);
                        fail <= 1'b1;
                    end
                    if (drop_c) overflow <= 1'b1;
                    // The final compare (or first failure) is fully accounted before leaving RUN.
                    if (run_end_c || (STOP_ON_FAIL && mis_c)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    equiv_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (start_ok_c),
        .push     (push_c),
        .push_rec (push_rec),
        .pop      (rec_ready),
        .head     (head),
        .empty    (empty),
        .full     (full),
        .drop_c   (drop_c)
    );

    assign rec_valid = ~empty;
    assign rec_cycle = rec_valid ? CW'(head.cyc) : '0;
    assign rec_diff  = rec_valid ? W'(head.diff) : '0;
    assign busy      = (state == WARMUP) || (state == RUN);

endmodule
